// File: rtl/hex_display_ctrl.sv
// Registered multi-digit 7-segment driver: capture on load, then decode with LZ blanking, blink, decimal check.
// Latency: load at edge N is shown on segs/dec_err after edge N+1; no backpressure, load is accepted every cycle.
// Optional lamp test (all segments lit) under macro HEX_DISPLAY_LAMP_TEST_EN.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic                    blank_lz,
  input  logic                    dec_mode,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`ifdef HEX_DISPLAY_LAMP_TEST_EN
  input  logic                    lamp_test,
`endif
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic                    dec_err
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_DARK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [4*NUM_DIGITS-1:0] val_q;
  logic                    blank_lz_q;
  logic                    dec_mode_q;
  logic [NUM_DIGITS-1:0]   blink_q;

  logic [CNT_W-1:0]        cnt_q;
  logic                    phase_q;

  logic [7*NUM_DIGITS-1:0] segs_d;
  logic                    dec_err_d;
  logic                    nz_seen;
  logic [3:0]              nib;
  logic [6:0]              glyph;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0011000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q      <= '0;
      blank_lz_q <= 1'b0;
      dec_mode_q <= 1'b0;
      blink_q    <= '0;
    end else if (load) begin
      val_q      <= din;
      blank_lz_q <= blank_lz;
      dec_mode_q <= dec_mode;
      blink_q    <= blink_mask;
    end
  end

  // Free-running blink prescaler; deliberately independent of load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Walk from the most significant digit down so nz_seen tells whether
  // any nibble at or above the current position is non-zero.
  always_comb begin
    segs_d    = '1;
    dec_err_d = 1'b0;
    nz_seen   = 1'b0;
    nib       = '0;
    glyph     = SEG_DARK;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib     = val_q[4*i +: 4];
      nz_seen = nz_seen | (nib != 4'h0);
      if (dec_mode_q && (nib > 4'd9)) begin
        dec_err_d = 1'b1;
      end
      if (blank_lz_q && (i != 0) && !nz_seen) begin
        glyph = SEG_DARK;
      end else if (phase_q && blink_q[i]) begin
        glyph = SEG_DARK;
      end else if (dec_mode_q && (nib > 4'd9)) begin
        glyph = SEG_DASH;
      end else begin
        glyph = hex_glyph(nib);
      end
      segs_d[7*i +: 7] = glyph;
    end
`ifdef HEX_DISPLAY_LAMP_TEST_EN
    if (lamp_test) begin
      segs_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      segs    <= '1;
      dec_err <= 1'b0;
    end else begin
      segs    <= segs_d;
      dec_err <= dec_err_d;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl (6 digits, BLINK_DIV=4); lamp test covered when HEX_DISPLAY_LAMP_TEST_EN is defined.
module tb_hex_display_ctrl;

  localparam int ND = 6;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G9 = 7'b0011000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] GD = 7'b1111111;
  localparam logic [6:0] GH = 7'b0111111;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            load = 1'b0;
  logic [4*ND-1:0] din = '0;
  logic            blank_lz = 1'b0;
  logic            dec_mode = 1'b0;
  logic [ND-1:0]   blink_mask = '0;
`ifdef HEX_DISPLAY_LAMP_TEST_EN
  logic            lamp_test = 1'b0;
`endif
  logic [7*ND-1:0] segs;
  logic            dec_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .din        (din),
    .blank_lz   (blank_lz),
    .dec_mode   (dec_mode),
    .blink_mask (blink_mask),
`ifdef HEX_DISPLAY_LAMP_TEST_EN
    .lamp_test  (lamp_test),
`endif
    .segs       (segs),
    .dec_err    (dec_err)
  );

  // One load pulse; returns at the negedge after the capturing edge.
  task automatic do_load(input logic [4*ND-1:0] d, input logic lz, input logic dm,
                         input logic [ND-1:0] bm);
    @(negedge clk);
    load = 1'b1; din = d; blank_lz = lz; dec_mode = dm; blink_mask = bm;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [7*ND-1:0] exp_s;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (segs !== '1) begin
      failures++; $display("FAIL reset_segs got=%h want=%h", segs, {(7*ND){1'b1}});
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_s = {G0, G0, G0, G0, G0, G0};
    checks++;
    if (segs !== exp_s) begin
      failures++; $display("FAIL post_reset_segs got=%h want=%h", segs, exp_s);
    end
    checks++;
    if (dec_err !== 1'b0) begin
      failures++; $display("FAIL post_reset_dec_err got=%b want=0", dec_err);
    end
  endtask

  task automatic test_hex_decode();
    logic [7*ND-1:0] exp_s;
    do_load(24'h12AB3F, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    exp_s = {G1, G2, GA, GB, G3, GF};
    checks++;
    if (segs !== exp_s) begin
      failures++; $display("FAIL hex_12AB3F got=%h want=%h", segs, exp_s);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (segs !== exp_s) begin
      failures++; $display("FAIL hex_hold got=%h want=%h", segs, exp_s);
    end
  endtask

  task automatic test_lz_blank();
    logic [7*ND-1:0] exp_s;
    do_load(24'h000042, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    exp_s = {GD, GD, GD, GD, G4, G2};
    checks++;
    if (segs !== exp_s) begin
      failures++; $display("FAIL lz_000042 got=%h want=%h", segs, exp_s);
    end
    do_load(24'h000000, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    exp_s = {GD, GD, GD, GD, GD, G0};
    checks++;
    if (segs !== exp_s) begin
      failures++; $display("FAIL lz_zero got=%h want=%h", segs, exp_s);
    end
    do_load(24'h010203, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    exp_s = {GD, G1, G0, G2, G0, G3};
    checks++;
    if (segs !== exp_s) begin
      failures++; $display("FAIL lz_inner_zero got=%h want=%h", segs, exp_s);
    end
  endtask

  task automatic test_dec_mode();
    logic [7*ND-1:0] exp_s;
    do_load(24'h0000A9, 1'b0, 1'b1, '0);
    @(posedge clk); #1;
    exp_s = {G0, G0, G0, G0, GH, G9};
    checks++;
    if (segs !== exp_s) begin
      failures++; $display("FAIL dec_A9_segs got=%h want=%h", segs, exp_s);
    end
    checks++;
    if (dec_err !== 1'b1) begin
      failures++; $display("FAIL dec_A9_err got=%b want=1", dec_err);
    end
    do_load(24'h000009, 1'b0, 1'b1, '0);
    @(posedge clk); #1;
    checks++;
    if (dec_err !== 1'b0) begin
      failures++; $display("FAIL dec_09_err got=%b want=0", dec_err);
    end
    exp_s = {G0, G0, G0, G0, G0, G9};
    checks++;
    if (segs !== exp_s) begin
      failures++; $display("FAIL dec_09_segs got=%h want=%h", segs, exp_s);
    end
    do_load(24'h0000A0, 1'b1, 1'b1, '0);
    @(posedge clk); #1;
    exp_s = {GD, GD, GD, GD, GH, G0};
    checks++;
    if (segs !== exp_s) begin
      failures++; $display("FAIL dec_lz_dash got=%h want=%h", segs, exp_s);
    end
    do_load(24'h0000A0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    exp_s = {G0, G0, G0, G0, GA, G0};
    checks++;
    if (segs !== exp_s || dec_err !== 1'b0) begin
      failures++; $display("FAIL hex_A0 got=%h/%b want=%h/0", segs, dec_err, exp_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [7*ND-1:0] exp_a, exp_b;
    exp_a = {G1, G2, GA, GB, G3, GF};
    exp_b = {G0, G0, G0, G0, G4, G2};
    @(negedge clk);
    load = 1'b1; din = 24'h12AB3F; blank_lz = 1'b0; dec_mode = 1'b0; blink_mask = '0;
    @(negedge clk);
    din = 24'h000042;
    @(posedge clk); #1;
    load = 1'b0;
    checks++;
    if (segs !== exp_a) begin
      failures++; $display("FAIL b2b_first got=%h want=%h", segs, exp_a);
    end
    @(posedge clk); #1;
    checks++;
    if (segs !== exp_b) begin
      failures++; $display("FAIL b2b_second got=%h want=%h", segs, exp_b);
    end
  endtask

`ifdef HEX_DISPLAY_LAMP_TEST_EN
  task automatic test_lamp();
    logic [7*ND-1:0] exp_s;
    do_load(24'h0000A0, 1'b1, 1'b1, '0);
    @(posedge clk); #1;
    exp_s = {GD, GD, GD, GD, GH, G0};
    lamp_test = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (segs !== '0) begin
      failures++; $display("FAIL lamp_on got=%h want=0", segs);
    end
    lamp_test = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (segs !== exp_s) begin
      failures++; $display("FAIL lamp_release got=%h want=%h", segs, exp_s);
    end
  endtask
`endif

  // Reset for one cycle, release with a blink load pending, then track the
  // 4-cycle dark/lit cadence; a stale counter or phase shifts the pattern.
  task automatic test_blink(input string tag);
    logic [7*ND-1:0] exp_s;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (segs !== '1 || dec_err !== 1'b0) begin
      failures++; $display("FAIL %s_reset_dark got=%h/%b want=all ones/0", tag, segs, dec_err);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    load = 1'b1; din = 24'h000005; blank_lz = 1'b0; dec_mode = 1'b0; blink_mask = 6'b000001;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      load = 1'b0;
      if (k >= 2) begin
        exp_s = {G0, G0, G0, G0, G0, ((((k - 1) / 4) % 2) == 1) ? GD : G5};
        checks++;
        if (segs !== exp_s) begin
          failures++; $display("FAIL %s_edge%0d got=%h want=%h", tag, k, segs, exp_s);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex_decode();
    test_lz_blank();
    test_dec_mode();
    test_back_to_back();
`ifdef HEX_DISPLAY_LAMP_TEST_EN
    test_lamp();
`endif
    test_blink("blink");
    repeat (2) @(posedge clk);
    test_blink("blink_midreset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Registered, parametrised multi-digit driver for the DE10-Standard 7-segment displays (HEX0..HEXn).
- Captures a packed nibble word on a load strobe and decodes each nibble to active-low segments.
- Adds leading-zero blanking, per-digit blinking from a clock prescaler, and a decimal-validity mode.
- Sits between the lab datapath and the HEX pins; replaces per-digit combinational decoders.

Parameters:
- NUM_DIGITS, 6, number of digits driven; legal range 1..8.
- BLINK_DIV, 25000000, clk cycles per blink half-period; at 50 MHz this gives a 1 Hz blink. Minimum 2.
- CNT_W, $clog2(BLINK_DIV), prescaler counter width; derived, not overridden.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- load, input, 1, single-cycle strobe; captures din and mode inputs when high.
- din, input, 4*NUM_DIGITS, packed nibbles; din[3:0] is digit 0, the rightmost digit.
- blank_lz, input, 1, enables leading-zero blanking; captured on load.
- dec_mode, input, 1, 1 = decimal display, 0 = hex display; captured on load.
- blink_mask, input, NUM_DIGITS, 1 = digit blinks; captured on load.
- segs, output, 7*NUM_DIGITS, active-low segments; segs[7i+6:7i] drives digit i, bit 6 = g, bit 0 = a.
- dec_err, output, 1, high while any captured digit is >9 in dec_mode.

Behaviour:
- Reset (reset_n low, asynchronous):
  - val_q = 0, blank_lz_q = 0, dec_mode_q = 0, blink_q = 0.
  - Prescaler counter = 0, blink phase = 0.
  - segs = all ones (all digits dark); dec_err = 0.
- Capture: on a rising edge with load = 1, register din, blank_lz, dec_mode and blink_mask. load = 0 holds the captured values indefinitely.
- Latency:
  - load sampled at edge N -> captured registers update at edge N.
  - segs and dec_err reflect the new values after edge N+1 (2-cycle pipeline: capture register, then output register).
  - Back-to-back loads are legal; each is displayed in turn, one cycle apart.
- Decode table (active-low, bit 6..0 = g..a), per digit:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- dec_mode = 1: any nibble >9 displays a dash (0111111), and dec_err = 1 (registered with segs).
- Leading-zero blanking: when blank_lz_q = 1, digit i (i >= 1) is dark (1111111) if nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never LZ-blanked, so value 0 shows a single "0".
- Blink prescaler:
  - Free-running counter counts 0..BLINK_DIV-1, then wraps to 0.
  - On wrap, blink phase toggles.
  - The prescaler is not reset by load.
- Blink output: when phase = 1, digits with blink_q[i] = 1 are dark. The change is visible one cycle after the phase toggle.
- Priority per digit, highest first: LZ blank, blink-dark, dash, hex glyph.
- Reset asserted mid-operation: all state clears immediately; the display is dark until the first clock edge after reset_n deasserts, then shows "0" in digit 0 with the other digits showing 0 glyphs (blank_lz_q = 0).
- No X propagation: all decode cases are fully specified.

Optional Feature:
- Macro: HEX_DISPLAY_LAMP_TEST_EN.
- Defined:
  - Adds input lamp_test (1 bit). While lamp_test = 1, all registered segs = 0 (every segment lit) after one cycle; captured state and the prescaler are unaffected.
  - On release, normal display resumes the next cycle.
  - lamp_test overrides LZ blanking, blink and dash.
- Not defined: the port is absent and behaviour is as above.

Test Plan:
- Reset, then run 2 clocks with no load -> segs digit 0..5 = 1000000 each, dec_err = 0; during reset segs = all ones.
- load din=24'h12AB3F, blank_lz=0, dec_mode=0 -> two cycles later:
  - digit0=0001110, digit1=0110000, digit2=0000011, digit3=0001000, digit4=0100100, digit5=1111001.
- load din=24'h000042, blank_lz=1 -> digits 5..2 = 1111111, digit1=0011001, digit0=0100100. Then load din=0 -> only digit0 = 1000000.
- load din=24'h0000A9, dec_mode=1 -> digit1 = 0111111, digit0 = 0011000, dec_err = 1. Then load din=24'h000009 -> dec_err = 0 two cycles later.
- With BLINK_DIV=4, load blink_mask=6'b000001, din=5:
  - digit0 alternates 0010010 / 1111111 every 4 cycles.
  - Other digits stay steady at 1000000.
- Assert reset_n low mid-blink for 1 cycle -> segs immediately all ones, counter and phase return to 0.
- With HEX_DISPLAY_LAMP_TEST_EN defined: lamp_test=1 -> all segs = 0. Release lamp_test -> prior display restored the next cycle.
